// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst types, response codes and write-slave FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } wr_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI FIXED/INCR/WRAP bursts; shared by read and write slaves.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step, aligned, incr, wrap_bytes, wrap_mask;

  always_comb begin
    step       = ADDR_WIDTH'(1) << size;
    aligned    = addr & ~(step - ADDR_WIDTH'(1));
    incr       = aligned + step;
    // Wrap window is (len+1) beats; only power-of-two lengths are legal, others are flagged upstream.
    wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wrap_mask  = wrap_bytes - ADDR_WIDTH'(1);
    unique case (burst)
      INCR:    next_addr = incr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI write slave backed by a byte-strobed word memory with a debug read port.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                         sig_clock,
  input  logic                         sig_reset,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [STRB_WIDTH-1:0]        wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);

  localparam int OFFS_W = $clog2(STRB_WIDTH);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int HI_W   = OFFS_W + IDX_W;

  wr_state_t             state, state_nx;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  burst_t                burst_q;
  logic [8:0]            beat_cnt;
  logic                  err_q, cfg_bad_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic aw_hs, w_hs, cfg_bad, wrap_len_ok, beat_over, addr_oob, len_mis, do_write, err_nx;
  logic [IDX_W-1:0] widx;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  assign wrap_len_ok = (awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15);
  assign cfg_bad = (awburst == RSVD) || ((awburst == WRAP) && !wrap_len_ok) ||
                   (awsize > 3'(OFFS_W));

  assign beat_over = beat_cnt > {1'b0, len_q};
  assign addr_oob  = (addr_q >> HI_W) != '0;
  assign len_mis   = wlast && (beat_cnt != {1'b0, len_q});
  assign do_write  = w_hs && !cfg_bad_q && !beat_over && !addr_oob;
  assign err_nx    = err_q | (w_hs & (addr_oob | beat_over | len_mis));
  assign widx      = addr_q[OFFS_W +: IDX_W];

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Ready/valid are gated by reset so nothing handshakes while it is held.
  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    unique case (state)
      IDLE: begin
        awready = ~sig_reset;
        if (awvalid) state_nx = DATA;
      end
      DATA: begin
        wready = ~sig_reset;
        if (wvalid && wlast) state_nx = RESP;
      end
      RESP: begin
        bvalid = ~sig_reset;
        if (bready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      cfg_bad_q <= 1'b0;
      beat_cnt  <= '0;
      bid       <= '0;
      bresp     <= OKAY;
    end else begin
      state <= state_nx;
      if (aw_hs) begin
        id_q      <= awid;
        addr_q    <= awaddr;
        len_q     <= awlen;
        size_q    <= awsize;
        burst_q   <= burst_t'(awburst);
        beat_cnt  <= '0;
        err_q     <= cfg_bad;
        cfg_bad_q <= cfg_bad;
      end
      if (w_hs) begin
        addr_q   <= next_addr;
        beat_cnt <= (beat_cnt == 9'h1FF) ? beat_cnt : beat_cnt + 9'd1;
        err_q    <= err_nx;
        // Response is captured with the last beat so it stays frozen through any B stall.
        if (wlast) begin
          bid   <= id_q;
          bresp <= err_nx ? SLVERR : OKAY;
        end
      end
    end
  end

  always_ff @(posedge sig_clock) begin
    if (do_write) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: burst types, range/length errors, B stall and reset abandon.
module tb_axi_wr_slave;
  import axi_pkg::*;

  localparam int AW = 32, DW = 64, IW = 32, MD = 256, SW = DW / 8;
  localparam int TMO = 50;

  logic            sig_clock = 1'b0, sig_reset = 1'b1;
  logic [IW-1:0]   awid = '0;
  logic [AW-1:0]   awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = '0;
  logic [1:0]      awburst = '0;
  logic            awvalid = 1'b0, awready;
  logic [DW-1:0]   wdata = '0;
  logic [SW-1:0]   wstrb = '0;
  logic            wlast = 1'b0, wvalid = 1'b0, wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid, bready = 1'b0;
  logic [7:0]      dbg_addr = '0;
  logic [DW-1:0]   dbg_data;

  int errs = 0, checks = 0;

  axi_wr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(MD)) dut (
    .sig_clock(sig_clock), .sig_reset(sig_reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 sig_clock = ~sig_clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    while (!awready && n < TMO) begin @(negedge sig_clock); n++; end
    if (n >= TMO) chk("aw_tmo", awready, 1);
    @(negedge sig_clock);
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
    int n = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && n < TMO) begin @(negedge sig_clock); n++; end
    if (n >= TMO) chk("w_tmo", wready, 1);
    @(negedge sig_clock);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic [IW-1:0] id, input logic [1:0] rsp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < TMO) begin @(negedge sig_clock); n++; end
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bid"}, bid, id);
    chk({tag, "_bresp"}, bresp, rsp);
    @(negedge sig_clock);
    bready = 1'b0;
  endtask

  task automatic mem_chk(input string tag, input logic [7:0] idx, input logic [DW-1:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    int n;
    logic seen;
    // Reset state
    repeat (3) @(negedge sig_clock);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    sig_reset = 1'b0;
    #1;
    chk("post_rst_awready", awready, 1);
    @(negedge sig_clock);

    // W presented in IDLE is held off
    wvalid = 1'b1;
    @(negedge sig_clock);
    chk("idle_wready", wready, 0);
    wvalid = 1'b0;

    // INCR 0x10, 4 beats -> words 2..5
    aw_send(32'h11, 32'h10, 8'd3, 3'd3, INCR);
    for (int i = 0; i < 4; i++) w_send(64'hA0 + DW'(i), 8'hFF, i == 3);
    b_take("incr", 32'h11, OKAY);
    for (int i = 0; i < 4; i++) mem_chk($sformatf("incr_mem%0d", i + 2), 8'(i + 2), 64'hA0 + DW'(i));

    // WRAP 0x18, 4 beats -> words 3,0,1,2
    aw_send(32'h22, 32'h18, 8'd3, 3'd3, WRAP);
    for (int i = 0; i < 4; i++) w_send(64'hB0 + DW'(i), 8'hFF, i == 3);
    b_take("wrap", 32'h22, OKAY);
    mem_chk("wrap_mem3", 8'd3, 64'hB0);
    mem_chk("wrap_mem0", 8'd0, 64'hB1);
    mem_chk("wrap_mem1", 8'd1, 64'hB2);
    mem_chk("wrap_mem2", 8'd2, 64'hB3);

    // FIXED 0x8, two half-word strobes merge into word 1
    aw_send(32'h33, 32'h8, 8'd1, 3'd3, FIXED);
    w_send(64'h11111111_22222222, 8'h0F, 1'b0);
    w_send(64'h33333333_44444444, 8'hF0, 1'b1);
    b_take("fixed", 32'h33, OKAY);
    mem_chk("fixed_mem1", 8'd1, 64'h33333333_22222222);

    // INCR from last word: beat 1 falls off the end and is dropped
    aw_send(32'h44, 32'h7F8, 8'd1, 3'd3, INCR);
    w_send(64'hC0, 8'hFF, 1'b0);
    w_send(64'hC1, 8'hFF, 1'b1);
    b_take("oob", 32'h44, SLVERR);
    mem_chk("oob_mem255", 8'd255, 64'hC0);
    mem_chk("oob_mem0", 8'd0, 64'hB1);

    // Early wlast on beat 1 of a 4-beat burst
    aw_send(32'h55, 32'h40, 8'd3, 3'd3, INCR);
    w_send(64'hD0, 8'hFF, 1'b0);
    w_send(64'hD1, 8'hFF, 1'b1);
    b_take("early", 32'h55, SLVERR);
    mem_chk("early_mem8", 8'd8, 64'hD0);
    mem_chk("early_mem9", 8'd9, 64'hD1);

    // Reserved burst: beats accepted, nothing written
    aw_send(32'h5A, 32'h10, 8'd1, 3'd3, RSVD);
    w_send(64'hEE0, 8'hFF, 1'b0);
    w_send(64'hEE1, 8'hFF, 1'b1);
    b_take("rsvd", 32'h5A, SLVERR);
    mem_chk("rsvd_mem2", 8'd2, 64'hB3);

    // B stall: bid/bresp must hold while bready is low
    aw_send(32'h66, 32'h60, 8'd0, 3'd3, INCR);
    w_send(64'hE0, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_bvalid", i), bvalid, 1);
      chk($sformatf("stall%0d_bid", i), bid, 32'h66);
      chk($sformatf("stall%0d_bresp", i), bresp, OKAY);
      @(negedge sig_clock);
    end
    b_take("stall", 32'h66, OKAY);

    // Reset mid-burst abandons the transaction; memory survives
    aw_send(32'h77, 32'h70, 8'd3, 3'd3, INCR);
    w_send(64'h99, 8'hFF, 1'b0);
    sig_reset = 1'b1;
    @(negedge sig_clock);
    chk("mid_rst_awready", awready, 0);
    sig_reset = 1'b0;
    #1;
    chk("mid_rst_awready_after", awready, 1);
    chk("mid_rst_wready", wready, 0);
    bready = 1'b1;
    seen = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge sig_clock);
      seen |= bvalid;
      n++;
    end
    bready = 1'b0;
    chk("abandon_no_b", seen, 0);
    mem_chk("abandon_mem14", 8'd14, 64'h99);
    mem_chk("keep_mem12", 8'd12, 64'hE0);

    // Slave still usable after the abandoned burst
    @(negedge sig_clock);
    aw_send(32'h88, 32'h20, 8'd0, 3'd3, INCR);
    w_send(64'hF4, 8'hFF, 1'b1);
    b_take("after", 32'h88, OKAY);
    mem_chk("after_mem4", 8'd4, 64'hF4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64: write data width; legal values are 32, 64 and 128.
REQ-003 The block SHALL have parameter ID_WIDTH, default 32: transaction ID width.
REQ-004 The block SHALL have parameter MEM_DEPTH, default 256: number of DATA_WIDTH-bit words of internal storage; must be a power of two.
REQ-005 The block SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: strobe width, derived and not overridden.
REQ-006 The block SHALL have the port sig_clock  in  1  the single clock; all logic is clocked on its rising edge.
REQ-007 The block SHALL have the port sig_reset  in  1  reset, synchronous and active-high.
REQ-008 The block SHALL have the following AW channel inputs: awid  in  ID_WIDTH; awaddr  in  ADDR_WIDTH; awlen  in  8; awsize  in  3; awburst  in  2; awvalid  in  1.
REQ-009 The block SHALL have the port awready  out  1  AW channel ready.
REQ-010 The block SHALL have the following W channel inputs: wdata  in  DATA_WIDTH; wstrb  in  STRB_WIDTH; wlast  in  1; wvalid  in  1.
REQ-011 The block SHALL have the port wready  out  1  W channel ready.
REQ-012 The block SHALL have the following B channel outputs: bid  out  ID_WIDTH; bresp  out  2; bvalid  out  1.
REQ-013 The block SHALL have the port bready  in  1  B channel ready.
REQ-014 The block SHALL have the port dbg_addr  in  $clog2(MEM_DEPTH)  memory word index for backdoor read.
REQ-015 The block SHALL have the port dbg_data  out  DATA_WIDTH  combinational read of mem[dbg_addr].

Function
REQ-016 The block SHALL implement the FSM states IDLE, DATA and RESP, with exactly one transaction outstanding.
REQ-017 FSM outputs SHALL be: awready=1 only in IDLE, wready=1 only in DATA, bvalid=1 only in RESP.
REQ-018 On an AW handshake in IDLE, the block SHALL latch awid, awaddr, awlen, awsize and awburst, clear the beat counter and the error flag, and enter DATA on the next cycle.
REQ-019 Each W handshake SHALL write bytes of mem[word index of the current beat address] for which wstrb[i]=1, at that clock edge; bytes with wstrb[i]=0 are unchanged.
REQ-020 The word index SHALL be (beat address >> log2(STRB_WIDTH)); a write issued on edge N is visible on dbg_data after edge N.
REQ-021 Beat address generation SHALL follow awburst:
  - FIXED (00): the address is constant.
  - INCR (01): the address is incremented by 2^awsize; the first beat is aligned down to 2^awsize after use.
  - WRAP (10): as INCR, but the address wraps to the boundary aligned to (awlen+1)*2^awsize.
REQ-022 Reserved awburst (11) SHALL set the error flag.
REQ-023 WRAP with awlen not in {1,3,7,15} SHALL set the error flag.
REQ-024 awsize > log2(STRB_WIDTH) SHALL set the error flag.
REQ-025 When the error flag is set by REQ-022, REQ-023 or REQ-024, every beat SHALL be accepted and no memory is written.
REQ-026 A beat whose byte address is >= MEM_DEPTH*STRB_WIDTH SHALL NOT be written and SHALL set the error flag; in-range beats of the same burst are still written.
REQ-027 The burst SHALL end on the W handshake with wlast=1, and the block enters RESP on the next cycle.
REQ-028 If wlast arrives with beat count != awlen, the block SHALL set the error flag.
REQ-029 Beats after beat awlen without wlast SHALL be accepted but not written, and SHALL set the error flag.
REQ-030 The beat counter SHALL be 9 bits and SHALL saturate at 511.
REQ-031 In RESP, bid SHALL equal the latched awid and bresp SHALL be OKAY (00), or SLVERR (10) if the error flag is set.
REQ-032 bid and bresp SHALL be held stable while bvalid=1 and bready=0.
REQ-033 A B handshake SHALL return the block to IDLE on the next cycle, so the minimum AW-to-AW spacing is awlen+3 cycles.
REQ-034 In IDLE, wvalid SHALL be ignored and no write occurs; W data presented before AW is held off by wready=0.

Reset
REQ-035 While sig_reset=1 at a rising edge, the block SHALL force: state IDLE, awready=0, wready=0, bvalid=0, bid=0, bresp=00, error flag and beat counter cleared.
REQ-036 awready SHALL be 1 in the first cycle after sig_reset deasserts.
REQ-037 Reset in DATA or RESP SHALL abandon the transaction without issuing a response.
REQ-038 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-039 Package axi_pkg SHALL hold: burst_t enum (FIXED, INCR, WRAP, RSVD), resp constants OKAY/EXOKAY/SLVERR/DECERR, and the wr_state_t enum.
REQ-040 The sub-module axi_burst_addr_gen SHALL compute the next beat address from address, awsize, awlen and awburst, purely combinationally, and SHALL be reusable by a future read slave.

Verification
REQ-041 The bench SHALL cover: INCR, awaddr=0x10, awlen=3, awsize=3, wstrb=0xFF, data 0xA0..A3 -> mem[2..5]=A0..A3, bresp=00, bid=awid.
REQ-042 The bench SHALL cover: WRAP, awaddr=0x18, awlen=3, awsize=3 -> words written in order 3,0,1,2, bresp=00.
REQ-043 The bench SHALL cover: FIXED, awaddr=0x8, awlen=1, wstrb 0x0F then 0xF0 -> mem[1] holds the low half from beat 0 and the high half from beat 1.
REQ-044 The bench SHALL cover: INCR, awaddr=(MEM_DEPTH-1)*8, awlen=1 -> last word written, beat 1 dropped, bresp=10.
REQ-045 The bench SHALL cover: awlen=3 with wlast on beat 1 -> RESP after 2 beats, bresp=10; next AW accepted.
REQ-046 The bench SHALL cover: bready=0 for 5 cycles, then sig_reset pulsed in DATA -> bid/bresp stable during the stall; after reset awready=1 and no B is issued for the abandoned burst.
